// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_reg_pkg : shared pipeline-stage types and boundary widths      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pipe_stage_reg_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } pipe_state_e;

   // Memory->writeback boundary: result + dest number + dest value + SP.
   localparam int MW_CTRL_WIDTH = 5;
   localparam int MW_DATA_WIDTH = 16 + 3 + 4 + 4;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_entry.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_entry : one {valid, ctrl, data} storage slot                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_stage_entry #(
   parameter int CTRL_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  clear,
   input  logic                  kill,
   input  logic [CTRL_WIDTH-1:0] ctrl_d,
   input  logic [DATA_WIDTH-1:0] data_d,
   output logic                  valid,
   output logic [CTRL_WIDTH-1:0] ctrl_q,
   output logic [DATA_WIDTH-1:0] data_q
);

   // clear zeroes ctrl (bubble = NOP); kill only drops valid; data is left stale.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid  <= 1'b0;
         ctrl_q <= '0;
         data_q <= '0;
      end else if (clear) begin
         valid  <= 1'b0;
         ctrl_q <= '0;
      end else if (load) begin
         valid  <= 1'b1;
         ctrl_q <= ctrl_d;
         data_q <= data_d;
      end else if (kill) begin
         valid  <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_reg : valid/ready pipeline register with skid entry and flush |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int CTRL_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            occupancy
);

   pipe_state_e           state;
   pipe_state_e           state_nxt;
   logic                  accept;
   logic                  consume;
   logic                  main_load;
   logic                  main_kill;
   logic                  main_from_skid;
   logic                  skid_load;
   logic                  skid_kill;
   logic                  main_valid;
   logic                  skid_valid;
   logic [CTRL_WIDTH-1:0] main_ctrl;
   logic [CTRL_WIDTH-1:0] skid_ctrl;
   logic [DATA_WIDTH-1:0] skid_data;
   logic [CTRL_WIDTH-1:0] main_ctrl_d;
   logic [DATA_WIDTH-1:0] main_data_d;

   assign in_ready  = (state != ST_FULL);
   assign accept    = in_valid & in_ready;
   assign consume   = main_valid & out_ready;
   assign out_valid = main_valid;
   assign out_ctrl  = main_valid ? main_ctrl : '0;
   assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

   always_comb begin
      state_nxt      = state;
      main_load      = 1'b0;
      main_kill      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_kill      = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  main_load = 1'b1;
                  state_nxt = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && consume) begin
                  main_load = 1'b1;
               end else if (accept) begin
                  skid_load = 1'b1;
                  state_nxt = ST_FULL;
               end else if (consume) begin
                  main_kill = 1'b1;
                  state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (consume) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_kill      = 1'b1;
                  state_nxt      = ST_ONE;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
   assign main_data_d = main_from_skid ? skid_data : in_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_EMPTY;
      else        state <= state_nxt;
   end

   pipe_stage_entry #(
      .CTRL_WIDTH (CTRL_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_main (
      .clk    (clk),
      .reset  (reset),
      .load   (main_load),
      .clear  (flush),
      .kill   (main_kill),
      .ctrl_d (main_ctrl_d),
      .data_d (main_data_d),
      .valid  (main_valid),
      .ctrl_q (main_ctrl),
      .data_q (out_data)
   );

   pipe_stage_entry #(
      .CTRL_WIDTH (CTRL_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk    (clk),
      .reset  (reset),
      .load   (skid_load),
      .clear  (flush),
      .kill   (skid_kill),
      .ctrl_d (in_ctrl),
      .data_d (in_data),
      .valid  (skid_valid),
      .ctrl_q (skid_ctrl),
      .data_q (skid_data)
   );

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, a one-entry skid buffer, and synchronous flush. It replaces the fixed-width, always-load stage registers between pipeline stages (e.g. memory→writeback). A downstream stall back-pressures the upstream stage without losing the word in flight, and a branch or interrupt can squash the stage into a bubble. Control bits of a bubble are forced to zero, so a bubble is a NOP to every consumer.

## Interface
- CTRL_WIDTH, 5: width of per-instruction control-signal vector; zeroed on bubbles.
- DATA_WIDTH, 32: width of opaque payload (result, destination number/value, SP, etc. concatenated by the instantiating stage).
- clk  input  1  stage clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash; empties the stage.
- in_valid  input  1  upstream offers a word.
- in_ready  output  1  stage can accept; registered (depends only on state).
- in_ctrl  input  CTRL_WIDTH  upstream control vector.
- in_data  input  DATA_WIDTH  upstream payload.
- out_valid  output  1  main entry holds a live word.
- out_ready  input  1  downstream consumes this cycle when out_valid.
- out_ctrl  output  CTRL_WIDTH  main control vector, or 0 when out_valid=0.
- out_data  output  DATA_WIDTH  main payload register (content unspecified-but-stable when out_valid=0).
- occupancy  output  2  live entries: 0, 1 or 2.

## Operation
- Storage: main entry (drives outputs) and skid entry, each holding {ctrl, data}.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- The state machine has three states: EMPTY (occ 0), ONE (main live), FULL (main+skid live).
- EMPTY: accept → main←in, go to ONE. Otherwise stay.
- ONE, accept & consume: main←in, stay in ONE.
- ONE, accept & !consume: skid←in, go to FULL.
- ONE, !accept & consume: go to EMPTY.
- ONE, neither: hold.
- FULL: in_ready=0. Consume → main←skid, go to ONE. Otherwise hold all.
- in_ready = (state != FULL).
- Order of precedence: reset > flush > handshake.
- flush=1: next state EMPTY regardless of in_valid/out_ready. A word accepted in the flush cycle is discarded. Data registers may retain stale contents. The ctrl registers of both entries are cleared to 0.
- Ordering is strict FIFO. A word never overtakes or duplicates another.
- Stable-hold: while out_valid & !out_ready, out_ctrl/out_data must not change.

## Timing
- Latency: word accepted at edge N appears on out_* after edge N when the stage was EMPTY, or when it was ONE with a simultaneous consume (1 cycle).
- Full-throughput: one word/cycle sustained when out_ready=1.
- Combinational paths: none from in_* or out_ready to in_ready. out_ctrl gating by out_valid is the only output logic.
- Reset (async assert, release sync'd externally):
  - state=EMPTY.
  - in_ready=1, out_valid=0.
  - out_ctrl=0, out_data=0.
  - occupancy=0.
  - Skid contents are 0.
- Reset mid-operation discards both entries immediately, without waiting for a clock edge.
- First cycle after flush: out_valid=0, in_ready=1.

## Structure
- A shared pipeline package holds:
  - the state enum (EMPTY/ONE/FULL);
  - default widths for each stage boundary (e.g. MW_CTRL_WIDTH=5, MW_DATA_WIDTH=16+3+4+4).
- One sub-module is natural: pipe_stage_entry, a {valid, ctrl, data} register with load and clear. It is instantiated twice (main, skid). The top level holds the FSM and the mux for main←in vs main←skid.

## Test plan
- Reset and first load:
  - Stimulus: reset low, then release. in_valid=1, in_ctrl=5'b10101, in_data=32'hDEAD_BEEF, out_ready=1.
  - Required response: outputs 0/in_ready=1 during reset. One cycle later out_valid=1, out_ctrl=5'b10101, out_data=DEAD_BEEF, occupancy=1.
- Back-pressure with skid:
  - Stimulus: stream data 1, 2, 3 with out_ready=0 from cycle 1.
  - Required response: word 1 held on outputs; word 2 in skid; occupancy=2; in_ready=0; word 3 not accepted. Release out_ready: outputs 1, 2, 3 in order, no loss or duplication.
- Flush:
  - Stimulus: stage FULL (words A, B) and in_valid=1 with C. Assert flush one cycle.
  - Required response: next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1. A, B and C never appear on the outputs.
- Async reset mid-stream:
  - Stimulus: drop reset between clock edges while FULL.
  - Required response: out_valid=0, out_ctrl=0, out_data=0 immediately, before the next edge.
- Throughput:
  - Stimulus: 100 random words, in_valid=1, out_ready=1 continuously.
  - Required response: 100 words out in 100 consecutive cycles, 1-cycle latency.
- Random stress:
  - Stimulus: random in_valid/out_ready/flush (flush 5%) with DATA_WIDTH=16, CTRL_WIDTH=3.
  - Required response: scoreboard matches, and out_data is stable whenever out_valid & !out_ready.
